// File: rtl/bus_xfer_unit_if.sv
// Handshake and bus signals of the register-file bus transfer unit.
interface bus_xfer_unit_if #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int SELW  = $clog2(NREGS)
) ();
  logic             start;
  logic             ext_load;
  logic [SELW-1:0]  src_sel;
  logic [SELW-1:0]  dst_sel;
  logic [WIDTH-1:0] ext_data;
  logic [WIDTH-1:0] bus;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, ext_load, src_sel, dst_sel, ext_data,
    input  bus, busy, done, err
  );

  modport slave (
    input  start, ext_load, src_sel, dst_sel, ext_data,
    output bus, busy, done, err
  );
endinterface

// File: rtl/bus_xfer_unit.sv
// Register file of NREGS x WIDTH sharing one internal bus. In IDLE the bus is a
// live mux of reg[src_sel]; a small FSM performs clocked reg-to-reg transfers
// (IDLE->READ->WRITE->DONE) and external loads (IDLE->WRITE->DONE).
module bus_xfer_unit #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int SELW  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  bus_xfer_unit_if.slave  bif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs [NREGS];
  logic [SELW-1:0]  src_q, dst_q;
  logic [WIDTH-1:0] bus_q;
  logic             err_q;
  logic [WIDTH-1:0] bus_c;

  // Index check done one bit wider so the compare is meaningful for any NREGS.
  function automatic logic in_range(input logic [SELW-1:0] sel);
    return {1'b0, sel} < (SELW+1)'(NREGS);
  endfunction

  function automatic logic [WIDTH-1:0] rd(input logic [SELW-1:0] sel);
    return in_range(sel) ? regs[sel] : '0;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and bus source selection
  always_comb begin
    state_d = state_q;
    bus_c   = '0;
    case (state_q)
      IDLE: begin
        bus_c = rd(bif.src_sel);
        if (bif.ext_load)   state_d = WRITE;
        else if (bif.start) state_d = READ;
      end
      READ: begin
        bus_c   = rd(src_q);
        state_d = WRITE;
      end
      WRITE: begin
        bus_c   = bus_q;
        state_d = DONE;
      end
      DONE: begin
        bus_c   = bus_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, bus latch and register-file write; reset abandons any write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= WIDTH'(32'd1 << (i % WIDTH));
      src_q <= '0;
      dst_q <= '0;
      bus_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bif.ext_load) begin
            dst_q <= bif.dst_sel;
            bus_q <= bif.ext_data;
            err_q <= !in_range(bif.dst_sel);
          end else if (bif.start) begin
            src_q <= bif.src_sel;
            dst_q <= bif.dst_sel;
            err_q <= !(in_range(bif.src_sel) && in_range(bif.dst_sel));
          end
        end
        READ:  bus_q <= bus_c;
        // Any out-of-range index in the request suppresses the write.
        WRITE: if (!err_q) regs[dst_q] <= bus_q;
        default: ;
      endcase
    end
  end

  assign bif.bus  = bus_c;
  assign bif.busy = (state_q != IDLE);
  assign bif.done = (state_q == DONE);
  assign bif.err  = (state_q == DONE) && err_q;

endmodule

// File: doc/bus_xfer_unit.md
# bus_xfer_unit

Parametrised register-file bus system: NREGS registers of WIDTH bits share one internal bus; a select drives any register onto the bus, and a small control FSM performs clocked register-to-register transfers and external loads over that bus. This is the sequential successor of the fixed 4×4-bit, select-only bus mux. It sits between the datapath control sequencer and the register bank in the COA bus-system exercises.

## Interface
- WIDTH, 4, bit width of each register and of the bus
- NREGS, 4, number of registers (2..16)
- SELW, $clog2(NREGS), width of select fields (derived; do not override)

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a transfer reg[src_sel] -> reg[dst_sel]; sampled only in IDLE
- src_sel  input  SELW  source register index
- dst_sel  input  SELW  destination register index
- ext_load  input  1  request load of ext_data into reg[dst_sel]; sampled only in IDLE
- ext_data  input  WIDTH  external data for ext_load
- bus  output  WIDTH  current bus value
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle pulse at completion of a transfer or load
- err  output  1  one-cycle pulse coincident with done when an index was out of range

## Operation
- Reset: reg[i] <= (1 << (i mod WIDTH)) truncated to WIDTH (WIDTH=4, NREGS=4 gives 0001, 0010, 0100, 1000); state <= IDLE; busy=0, done=0, err=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE: bus = reg[src_sel] combinationally (live mux, as in the select-only system).
  - ext_load=1: capture dst_sel and ext_data, go to WRITE with bus source = captured ext_data.
  - Else start=1: capture src_sel and dst_sel, go to READ.
  - ext_load has priority over start in the same cycle; the losing start is dropped, not queued.
- READ: bus = reg[captured src]; the bus value is latched into an internal bus register; go to WRITE.
- WRITE: bus = latched value (or captured ext_data); reg[captured dst] <= bus at the end of the cycle; go to DONE.
- DONE: done=1, bus holds the written value; go to IDLE.
- start and ext_load are ignored while busy=1; src_sel and dst_sel changes during a transfer have no effect.
- src == dst is legal; the register is rewritten with its own value.
- Out-of-range index (>= NREGS, possible when NREGS is not a power of two): a read returns all-zero on the bus, a write is suppressed, and err pulses with done.
- Only the destination register changes; all others hold.

## Timing
- Transfer: start sampled at edge E0; READ in the cycle after E0; WRITE after E1; the destination register updates at E2; done=1 in the cycle after E2; IDLE after E3. start-to-done latency is 3 cycles.
- ext_load: sampled at E0; WRITE after E0; the register updates at E1; done in the cycle after E1. Latency is 2 cycles.
- Back-to-back: a new start can be sampled in the first IDLE cycle after DONE, giving a throughput of one transfer per 4 cycles.
- rst during any state: next cycle is IDLE, all registers return to reset values, done/err/busy are 0, and the in-flight write is abandoned even if it is in WRITE.
- done and err are registered outputs (state-decoded from registers), with no combinational path from the inputs. bus is combinational only in IDLE.

## Test plan
- Reset, then sweep src_sel 0..3 in IDLE -> bus = 0001, 0010, 0100, 1000 (WIDTH=4, NREGS=4).
- start with src=0, dst=3 -> busy for 3 cycles, done in the 4th cycle, reg3 = 0001, bus in IDLE with src=3 reads 0001, other registers unchanged.
- ext_load=1 with ext_data=1010, dst=2, and start=1 in the same cycle -> only the load occurs, done after 2 cycles, reg2 = 1010; the start is dropped.
- start pulsed again while busy, and src/dst toggled mid-transfer -> exactly one transfer using the originally captured indices.
- NREGS=3, start with src=3, dst=1 -> done with err=1, reg1 = 0000 is not written (reg1 stays 0010); then ext_load to dst=3 -> err=1, no register changes.
- rst asserted in the WRITE state of a transfer src=1, dst=0 -> reg0 remains 0001 after reset, busy=0, no done pulse.
